msrh_brtag_mgr: RTL
===================

// Module: msrh_brtag_mgr
// PURPOSE
//  Branch-tag manager: the receiving end of the BRU's ex3 branch-update stream.
//  - Allocates branch tags (brtags) to branch instructions at dispatch.
//  - Tracks each tag's dependency mask of older in-flight branches.
//  - On branch resolution, frees the resolved tag and broadcasts a registered clear/kill mask.
//  - Sits between rename/dispatch and all schedulers.
// PARAMETERS
//  BRTAG_SIZE  8   in-flight branch tags; must be a power of two, >=2
//  DISP_SIZE   5   dispatch slots per group
//  BRTAG_W     $clog2(BRTAG_SIZE)  tag index width (derived, not overridable)
// PORTS
//  i_clk             in   1                    clock
//  i_reset           in   1                    synchronous, active-high reset
//  i_disp_br         in   DISP_SIZE            slot s holds a branch
//  i_disp_fire       in   1                    dispatch group accepted this cycle
//  o_alloc_ready     out  1                    enough free tags for the group's branches
//  o_disp_brtag      out  DISP_SIZE x BRTAG_W  tag assigned to slot s (valid where i_disp_br[s])
//  o_disp_brmask     out  DISP_SIZE x BRTAG_SIZE  older-branch mask inherited by slot s
//  i_br_upd_valid    in   1                    BRU ex3 branch update
//  i_br_upd_brtag    in   BRTAG_W              tag being resolved
//  i_br_upd_mispred  in   1                    resolution is a mispredict
//  i_flush           in   1                    pipeline flush (exception/commit redirect)
//  o_resolve_valid   out  1                    registered resolve broadcast
//  o_resolve_clear   out  BRTAG_SIZE           tags to drop from every brmask (correct path)
//  o_resolve_kill    out  BRTAG_SIZE           tags whose dependents are squashed (mispredict)
//  o_free_cnt        out  BRTAG_W+1            number of free tags
// BEHAVIOUR
//  - State per tag t: r_valid[t], r_dep[t][BRTAG_SIZE] (older branches live at allocation).
//  - Reset or flush: r_valid=0, r_dep=0, all resolve outputs 0, o_free_cnt=BRTAG_SIZE next cycle.
//    Flush overrides fire and br_upd in the same cycle.
//  - Allocation:
//    - Free tags are picked lowest-index first, assigned to branch slots in ascending slot order.
//    - o_alloc_ready = popcount(~r_valid) >= popcount(i_disp_br) && !(i_br_upd_valid && i_br_upd_mispred).
//    - A group with no branches is always ready unless a mispredict is being resolved.
//    - State updates only on i_disp_fire && o_alloc_ready. fire && !ready is a protocol error:
//      ignored and asserted.
//  - o_disp_brmask[s] (combinational):
//    = (r_valid minus any tag resolved this cycle) | tags allocated to branch slots < s.
//    A branch's own tag is NOT in its own mask. r_dep of the new tag = o_disp_brmask[s].
//  - Resolve, when i_br_upd_valid && r_valid[tag]:
//    - Correct path: free tag; clear bit tag from every r_dep.
//      Next cycle: o_resolve_valid=1, o_resolve_clear=onehot(tag), o_resolve_kill=0.
//    - Mispredict: kill set K = onehot(tag) | {t : r_valid[t] && r_dep[t][tag]}; all of K freed.
//      Next cycle: o_resolve_valid=1, o_resolve_kill=K, o_resolve_clear=0.
//  - Resolve of an invalid tag: no state change, no broadcast (asserted).
//  - Latency: resolve to broadcast is 1 cycle. Freed tags become allocatable the next cycle;
//    no same-cycle reuse.
//  - Simultaneous correct resolve + fire: both apply. New tags never collide with the freed tag.
//  - o_free_cnt is registered, equal to popcount(~r_valid).
// CONFIGURATION
//  - MSRH_BRTAG_STATS_EN defined:
//    - Adds o_stat_resolve_cnt[31:0] and o_stat_mispred_cnt[31:0].
//    - Counters increment on each broadcast and each kill broadcast; reset/flush clear neither
//      except i_reset (to 0). Counters saturate at 2^32-1.
//  - Undefined: ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  - msrh_pkg: brtag_t (logic [BRTAG_W-1:0]), brmask_t (logic [BRTAG_SIZE-1:0]), BRTAG_SIZE constant.
//  - Sub-module msrh_brtag_pick: combinational, outputs up to DISP_SIZE one-hot lowest free bits
//    from a free vector. Instantiated once.
//  - Everything else (tag table, resolve logic, broadcast regs, stats) is inline.
// TESTING
//  1 Reset: i_reset 1 cycle -> o_free_cnt=8, o_resolve_valid=0, o_alloc_ready=1.
//  2 Alloc: i_disp_br=5'b00101, fire -> tags 0 and 1. brmask slot0=0, slot2=8'h01.
//    Next cycle o_free_cnt=6.
//  3 Correct resolve: tags 0,1,2 live (2 depends on 0,1), resolve tag1 ->
//    next cycle clear=8'h02, r_dep[2]=8'h01, free_cnt+1.
//  4 Mispredict: tags 0..3 chained, mispredict tag1 -> kill=8'h0E. The same-cycle fire is
//    refused (ready=0). free_cnt=7.
//  5 Full: 8 tags live, group with 1 branch -> ready=0. Resolve tag 5 -> ready=0 this cycle;
//    next cycle ready=1, allocates tag 5.
//  6 Flush while mispredict + fire -> no broadcast. Next cycle free_cnt=8, all tags free.

Source files
------------

// File: rtl/msrh_pkg.sv
`default_nettype none
// ============================================================================
// msrh_pkg : shared branch-tag sizing constants and tag/mask types.
// Rev 1.0
// ============================================================================
package msrh_pkg;

  localparam int BRTAG_SIZE = 8;
  localparam int BRTAG_W    = $clog2(BRTAG_SIZE);
  localparam int DISP_SIZE  = 5;

  typedef logic [BRTAG_W-1:0]    brtag_t;
  typedef logic [BRTAG_SIZE-1:0] brmask_t;

endpackage
`default_nettype wire

// File: rtl/msrh_brtag_pick.sv
`default_nettype none
// ============================================================================
// msrh_brtag_pick : returns the K lowest set bits of a free vector, one-hot each.
// Rev 1.0
// ============================================================================
module msrh_brtag_pick #(
  parameter int N = 8,
  parameter int K = 5
) (
  input  logic [N-1:0]        free_i,
  output logic [K-1:0][N-1:0] pick_o
);
  import msrh_pkg::*;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  always_comb begin
    logic [N-1:0] rem;
    rem    = free_i;
    pick_o = '0;
    for (int k = 0; k < K; k++) begin
      // x & -x isolates the lowest set bit; an empty remainder yields zero
      pick_o[k] = rem & (~rem + ONE);
      rem       = rem & ~pick_o[k];
    end
  end

endmodule
`default_nettype wire

// File: rtl/msrh_brtag_mgr.sv
`default_nettype none
// ============================================================================
// msrh_brtag_mgr : branch-tag allocator, dependency tracker, resolve broadcaster.
// MSRH_BRTAG_STATS_EN adds saturating resolve/mispredict counters.  Rev 1.0
// ============================================================================
module msrh_brtag_mgr #(
  parameter int  BRTAG_SIZE = msrh_pkg::BRTAG_SIZE,
  parameter int  DISP_SIZE  = msrh_pkg::DISP_SIZE,
  localparam int BRTAG_W    = $clog2(BRTAG_SIZE)
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic [DISP_SIZE-1:0]                i_disp_br,
  input  logic                                i_disp_fire,
  output logic                                o_alloc_ready,
  output logic [DISP_SIZE-1:0][BRTAG_W-1:0]   o_disp_brtag,
  output logic [DISP_SIZE-1:0][BRTAG_SIZE-1:0] o_disp_brmask,
  input  logic                                i_br_upd_valid,
  input  logic [BRTAG_W-1:0]                  i_br_upd_brtag,
  input  logic                                i_br_upd_mispred,
  input  logic                                i_flush,
  output logic                                o_resolve_valid,
  output logic [BRTAG_SIZE-1:0]               o_resolve_clear,
  output logic [BRTAG_SIZE-1:0]               o_resolve_kill,
  output logic [BRTAG_W:0]                    o_free_cnt
`ifdef MSRH_BRTAG_STATS_EN
  ,
  output logic [31:0]                         o_stat_resolve_cnt,
  output logic [31:0]                         o_stat_mispred_cnt
`endif
);
  import msrh_pkg::*;

  localparam int FREE_W = BRTAG_W + 1;

  logic [BRTAG_SIZE-1:0] valid_q, valid_d;
  logic [BRTAG_SIZE-1:0] dep_q [BRTAG_SIZE];
  logic [BRTAG_SIZE-1:0] dep_d [BRTAG_SIZE];
  logic                  res_valid_q, res_valid_d;
  logic [BRTAG_SIZE-1:0] clear_q, clear_d;
  logic [BRTAG_SIZE-1:0] kill_q, kill_d;
  logic [FREE_W-1:0]     free_cnt_q, free_cnt_d;

  logic [DISP_SIZE-1:0][BRTAG_SIZE-1:0] w_pick;
  logic [DISP_SIZE-1:0][BRTAG_SIZE-1:0] w_alloc_oh;
  logic [BRTAG_SIZE-1:0]                w_upd_oh;
  logic [BRTAG_SIZE-1:0]                w_kill_set;
  logic [BRTAG_SIZE-1:0]                w_freed;
  logic                                 w_res_hit;
  logic                                 w_alloc_en;

  msrh_brtag_pick #(
    .N (BRTAG_SIZE),
    .K (DISP_SIZE)
  ) u_pick (
    .free_i (~valid_q),
    .pick_o (w_pick)
  );

  // Resolve: a mispredict frees the tag plus every live younger dependent
  always_comb begin
    w_upd_oh                 = '0;
    w_upd_oh[i_br_upd_brtag] = 1'b1;
    w_res_hit                = i_br_upd_valid && valid_q[i_br_upd_brtag];
    w_kill_set               = w_upd_oh;
    for (int t = 0; t < BRTAG_SIZE; t++) begin
      if (valid_q[t] && dep_q[t][i_br_upd_brtag]) w_kill_set[t] = 1'b1;
    end
    w_freed = '0;
    if (w_res_hit) w_freed = i_br_upd_mispred ? w_kill_set : w_upd_oh;
  end

  // Branch slots consume picked free tags in ascending slot order
  always_comb begin
    int                    rank;
    logic [BRTAG_SIZE-1:0] acc;
    rank          = 0;
    acc           = valid_q & ~w_freed;
    w_alloc_oh    = '0;
    o_disp_brtag  = '0;
    o_disp_brmask = '0;
    for (int s = 0; s < DISP_SIZE; s++) begin
      o_disp_brmask[s] = acc;
      if (i_disp_br[s]) begin
        for (int k = 0; k < DISP_SIZE; k++) begin
          if (k == rank) w_alloc_oh[s] = w_pick[k];
        end
        for (int t = 0; t < BRTAG_SIZE; t++) begin
          if (w_alloc_oh[s][t]) o_disp_brtag[s] = BRTAG_W'(t);
        end
        acc  = acc | w_alloc_oh[s];
        rank = rank + 1;
      end
    end
  end

  assign o_alloc_ready = ($countones(~valid_q) >= $countones(i_disp_br)) &&
                         !(i_br_upd_valid && i_br_upd_mispred);
  assign w_alloc_en    = i_disp_fire && o_alloc_ready;

  always_comb begin
    valid_d = valid_q & ~w_freed;
    for (int t = 0; t < BRTAG_SIZE; t++) begin
      dep_d[t] = w_freed[t] ? '0 : dep_q[t];
      if (w_res_hit && !i_br_upd_mispred) dep_d[t][i_br_upd_brtag] = 1'b0;
    end
    if (w_alloc_en) begin
      for (int s = 0; s < DISP_SIZE; s++) begin
        if (i_disp_br[s]) begin
          valid_d = valid_d | w_alloc_oh[s];
          for (int t = 0; t < BRTAG_SIZE; t++) begin
            if (w_alloc_oh[s][t]) dep_d[t] = o_disp_brmask[s];
          end
        end
      end
    end
    res_valid_d = w_res_hit;
    clear_d     = (w_res_hit && !i_br_upd_mispred) ? w_upd_oh : '0;
    kill_d      = (w_res_hit && i_br_upd_mispred) ? w_kill_set : '0;
    free_cnt_d  = FREE_W'($countones(~valid_d));
    // Flush wins over any same-cycle allocation or resolve
    if (i_flush) begin
      valid_d     = '0;
      for (int t = 0; t < BRTAG_SIZE; t++) dep_d[t] = '0;
      res_valid_d = 1'b0;
      clear_d     = '0;
      kill_d      = '0;
      free_cnt_d  = FREE_W'(BRTAG_SIZE);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q     <= '0;
      for (int t = 0; t < BRTAG_SIZE; t++) dep_q[t] <= '0;
      res_valid_q <= 1'b0;
      clear_q     <= '0;
      kill_q      <= '0;
      free_cnt_q  <= FREE_W'(BRTAG_SIZE);
    end else begin
      valid_q     <= valid_d;
      for (int t = 0; t < BRTAG_SIZE; t++) dep_q[t] <= dep_d[t];
      res_valid_q <= res_valid_d;
      clear_q     <= clear_d;
      kill_q      <= kill_d;
      free_cnt_q  <= free_cnt_d;
    end
  end

  assign o_resolve_valid = res_valid_q;
  assign o_resolve_clear = clear_q;
  assign o_resolve_kill  = kill_q;
  assign o_free_cnt      = free_cnt_q;

`ifdef MSRH_BRTAG_STATS_EN
  logic [31:0] stat_resolve_q;
  logic [31:0] stat_mispred_q;

  // Counted as the broadcast is loaded; only i_reset clears them
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stat_resolve_q <= '0;
      stat_mispred_q <= '0;
    end else begin
      if (res_valid_d && (stat_resolve_q != 32'hFFFF_FFFF))
        stat_resolve_q <= stat_resolve_q + 32'd1;
      if (res_valid_d && (kill_d != '0) && (stat_mispred_q != 32'hFFFF_FFFF))
        stat_mispred_q <= stat_mispred_q + 32'd1;
    end
  end

  assign o_stat_resolve_cnt = stat_resolve_q;
  assign o_stat_mispred_cnt = stat_mispred_q;
`endif

`ifndef SYNTHESIS
  a_fire_when_ready: assert property (@(posedge i_clk) disable iff (i_reset || i_flush)
    !(i_disp_fire && !o_alloc_ready));
  a_resolve_live_tag: assert property (@(posedge i_clk) disable iff (i_reset || i_flush)
    !(i_br_upd_valid && !valid_q[i_br_upd_brtag]));
`endif

endmodule
`default_nettype wire
